// File: rtl/ch3_wave_gen_pkg.sv
// Shared types and constants for the channel 3 wave-playback engine.
package apu_ch3_pkg;

   localparam int FREQ_W   = 11;
   localparam int POS_W    = 5;
   localparam int TRIG_DLY = 3;
   localparam int DLY_W    = $clog2(TRIG_DLY);

   localparam logic [FREQ_W-1:0] FREQ_MAX = 11'h7FF;

   localparam logic [1:0] VOL_MUTE = 2'b00;
   localparam logic [1:0] VOL_100  = 2'b01;
   localparam logic [1:0] VOL_50   = 2'b10;
   localparam logic [1:0] VOL_25   = 2'b11;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      FETCH = 2'd3
   } ch3_state_t;

   // NR32 volume code applied to a 4-bit wave sample
   function automatic logic [3:0] vol_scale(input logic [3:0] s, input logic [1:0] v);
      case (v)
         VOL_MUTE: return 4'h0;
         VOL_100:  return s;
         VOL_50:   return s >> 1;
         default:  return s >> 2;
      endcase
   endfunction

endpackage

// File: rtl/ch3_wave_gen_if.sv
// Channel 3 control / wave RAM interface. The register block and RAM side use
// the master modport, the playback engine uses the slave modport.
// CH3_WAVE_LOCK_EN adds the CPU wave RAM lock outputs.
interface ch3_wave_gen_if;
   import apu_ch3_pkg::*;

   logic                dac_en;
   logic [1:0]          vol;
   logic [FREQ_W-1:0]   freq;
   logic                trig;
   logic                len_expire;
   logic [7:0]          wave_data;
   logic [POS_W-2:0]    wave_addr;
   logic                wave_rd;
   logic [POS_W-1:0]    wave_pos;
   logic                ch3_active;
   logic [3:0]          ch3_out;
`ifdef CH3_WAVE_LOCK_EN
   logic                cpu_wave_lock;
   logic [POS_W-2:0]    cpu_wave_addr;

   modport master (
      output dac_en, vol, freq, trig, len_expire, wave_data,
      input  wave_addr, wave_rd, wave_pos, ch3_active, ch3_out,
             cpu_wave_lock, cpu_wave_addr
   );
   modport slave (
      input  dac_en, vol, freq, trig, len_expire, wave_data,
      output wave_addr, wave_rd, wave_pos, ch3_active, ch3_out,
             cpu_wave_lock, cpu_wave_addr
   );
`else
   modport master (
      output dac_en, vol, freq, trig, len_expire, wave_data,
      input  wave_addr, wave_rd, wave_pos, ch3_active, ch3_out
   );
   modport slave (
      input  dac_en, vol, freq, trig, len_expire, wave_data,
      output wave_addr, wave_rd, wave_pos, ch3_active, ch3_out
   );
`endif

endinterface

// File: rtl/ch3_wave_gen_vol_shift.sv
// Volume shifter with output register; also used stand-alone by the mixer bench.
module ch3_vol_shift
   import apu_ch3_pkg::*;
(
   input  logic       cery_2mhz,
   input  logic       apu_reset,
   input  logic [3:0] sample,
   input  logic [1:0] vol,
   input  logic       en,
   output logic [3:0] out_q
);

   logic [3:0] scaled;

   // shift the sample by the volume code, muted when the channel is off
   always_comb begin
      scaled = 4'h0;
      if (en) scaled = vol_scale(sample, vol);
   end

   // register the scaled sample toward the mixer
   always_ff @(posedge cery_2mhz or posedge apu_reset) begin
      if (apu_reset) out_q <= 4'h0;
      else           out_q <= scaled;
   end

endmodule

// File: rtl/ch3_wave_gen.sv
// Channel 3 wave-playback engine: frequency timer, wave position stepping,
// wave RAM fetch/nibble select and volume-scaled output.
// Optional feature macro: CH3_WAVE_LOCK_EN (CPU wave RAM lock outputs).
//
// state | meaning
// OFF   | channel inactive, position and sample held
// START | trigger delay, timer frozen at freq
// RUN   | timer counting toward 0x7FF
// FETCH | wave byte read cycle, nibble latched at end of cycle
module ch3_wave_gen
   import apu_ch3_pkg::*;
(
   input  logic         cery_2mhz,
   input  logic         apu_reset,
   ch3_wave_gen_if.slave bus
);

   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(TRIG_DLY - 1);

   ch3_state_t          state;
   logic [FREQ_W-1:0]   counter;
   logic [POS_W-1:0]    pos;
   logic [3:0]          sample_buf;
   logic                wave_rd_q;
   logic [POS_W-2:0]    wave_addr_q;
   logic [DLY_W-1:0]    dly;
   logic                active;
   logic [3:0]          ch3_out_q;

   logic [POS_W-1:0]    pos_nxt;
   logic                timer_tc;
   logic                trig_ok;
   logic                off_req;

   assign pos_nxt  = pos + 1'b1;
   assign timer_tc = (counter == FREQ_MAX);
   assign trig_ok  = bus.trig && bus.dac_en;
   // a trigger outranks length expiry, but never a DAC power-down
   assign off_req  = !bus.dac_en || (bus.len_expire && !bus.trig);

   // playback sequencer: timer, position, fetch strobe and sample latch
   always_ff @(posedge cery_2mhz or posedge apu_reset) begin
      if (apu_reset) begin
         state       <= OFF;
         counter     <= '0;
         pos         <= '0;
         sample_buf  <= 4'h0;
         wave_rd_q   <= 1'b0;
         wave_addr_q <= '0;
         dly         <= '0;
         active      <= 1'b0;
      end else if (off_req) begin
         state     <= OFF;
         active    <= 1'b0;
         wave_rd_q <= 1'b0;
      end else if (trig_ok) begin
         // restart from any state; an in-flight fetch is dropped unlatched
         state     <= START;
         active    <= 1'b1;
         pos       <= '0;
         counter   <= bus.freq;
         dly       <= DLY_LOAD;
         wave_rd_q <= 1'b0;
      end else begin
         case (state)
            OFF: begin
               wave_rd_q <= 1'b0;
            end
            START: begin
               wave_rd_q <= 1'b0;
               if (dly == '0) state <= RUN;
               else           dly   <= dly - 1'b1;
            end
            RUN, FETCH: begin
               if (state == FETCH)
                  sample_buf <= pos[0] ? bus.wave_data[3:0] : bus.wave_data[7:4];
               if (timer_tc) begin
                  counter     <= bus.freq;
                  pos         <= pos_nxt;
                  wave_addr_q <= pos_nxt[POS_W-1:1];
                  wave_rd_q   <= 1'b1;
                  state       <= FETCH;
               end else begin
                  counter   <= counter + 1'b1;
                  wave_rd_q <= 1'b0;
                  state     <= RUN;
               end
            end
            default: state <= OFF;
         endcase
      end
   end

   ch3_vol_shift u_vol_shift (
      .cery_2mhz (cery_2mhz),
      .apu_reset (apu_reset),
      .sample    (sample_buf),
      .vol       (bus.vol),
      .en        (active && bus.dac_en),
      .out_q     (ch3_out_q)
   );

   assign bus.wave_addr  = wave_addr_q;
   assign bus.wave_rd    = wave_rd_q;
   assign bus.wave_pos   = pos;
   assign bus.ch3_active = active;
   assign bus.ch3_out    = ch3_out_q;

`ifdef CH3_WAVE_LOCK_EN
   // CPU wave RAM accesses land on the byte being played, only in the fetch cycle
   assign bus.cpu_wave_lock = active && (state == FETCH);
   assign bus.cpu_wave_addr = wave_addr_q;
`endif

endmodule
